// File: rtl/pipe_stage_pkg.sv
// Shared types for the elastic pipeline buffer.
// State encoding doubles as the held-beat count.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_stage_state_e;

  localparam int unsigned PS_DEF_WIDTH = 41;

  function automatic logic [1:0] ps_occupancy(
    input pipe_stage_state_e s
  );
    logic [1:0] n;
    n = 2'd0;
    unique case (s)
      PS_ONE:  n = 2'd1;
      PS_TWO:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One payload register: clear-to-BUBBLE beats load beats hold.
// Ports: clk, reset (sync, high), load, clear, d -> q.
module pipe_stage_slot
  import pipe_stage_pkg::*;
#(
  parameter int unsigned      WIDTH  = PS_DEF_WIDTH,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = BUBBLE;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= BUBBLE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline buffer; PIPE_STAGE_SKID_EN adds skid slot.
// Ports: clk, reset, flush, in_*, out_*, occupancy (beats held).
module pipe_stage_elastic
  import pipe_stage_pkg::*;
#(
  parameter int unsigned      WIDTH  = PS_DEF_WIDTH,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_stage_state_e state_q;
  pipe_stage_state_e state_d;

  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             main_clear;
  logic [WIDTH-1:0] main_din;
  logic [WIDTH-1:0] main_q;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_load;
  logic             skid_clear;
  logic [WIDTH-1:0] skid_q;
`endif

  assign out_valid = (state_q != PS_EMPTY);

`ifdef PIPE_STAGE_SKID_EN
  // Registered ready: breaks the ready chain.
  assign in_ready = (state_q != PS_TWO);
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_din   = in_data;
`ifdef PIPE_STAGE_SKID_EN
    skid_load  = 1'b0;
    skid_clear = 1'b0;
`endif
    if (flush) begin
      // Offered beat is dropped; a beat
      // leaving this cycle is still done.
      state_d    = PS_EMPTY;
      main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d   = PS_ONE;
            main_load = 1'b1;
          end
        end
        PS_ONE: begin
          unique case (1'b1)
            (in_fire && out_fire): begin
              main_load = 1'b1;
            end
`ifdef PIPE_STAGE_SKID_EN
            (in_fire && !out_fire): begin
              state_d   = PS_TWO;
              skid_load = 1'b1;
            end
`endif
            (!in_fire && out_fire): begin
              state_d    = PS_EMPTY;
              main_clear = 1'b1;
            end
            default: ;
          endcase
        end
`ifdef PIPE_STAGE_SKID_EN
        PS_TWO: begin
          // Skid is younger: promote it.
          if (out_fire) begin
            state_d    = PS_ONE;
            main_load  = 1'b1;
            main_din   = skid_q;
            skid_clear = 1'b1;
          end
        end
`endif
        default: begin
          state_d    = PS_EMPTY;
          main_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PS_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_stage_slot #(
    .WIDTH  (WIDTH),
    .BUBBLE (BUBBLE)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_din),
    .q     (main_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_stage_slot #(
    .WIDTH  (WIDTH),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_data),
    .q     (skid_q)
  );
`endif

  // Main slot is cleared on going empty,
  // so it reads BUBBLE when invalid.
  assign out_data  = main_q;
  assign occupancy = ps_occupancy(state_q);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic, both PIPE_STAGE_SKID_EN builds.
// Reference: queue of held beats with capacity 1 or 2.
module tb_pipe_stage_elastic;

  localparam int W = 41;
  localparam logic [W-1:0] BUB = 41'h13;
  localparam logic [W-1:0] AA  = 41'h0AA;
  localparam logic [W-1:0] BB  = 41'h0BB;
  localparam logic [W-1:0] CC  = 41'h0CC;
  localparam logic [W-1:0] DD  = 41'h0DD;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] mq[$];

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .WIDTH  (W),
    .BUBBLE (BUB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  function automatic bit m_ready();
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || (out_ready == 1'b1);
  endfunction

  function automatic bit m_valid();
    return mq.size() > 0;
  endfunction

  function automatic logic [W-1:0] m_data();
    if (mq.size() > 0) return mq[0];
    return BUB;
  endfunction

  function automatic logic [1:0] m_occ();
    return 2'(mq.size());
  endfunction

  task automatic drive(input bit iv, input logic [W-1:0] id,
                       input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance one clock and update the reference queue.
  task automatic adv();
    bit inf;
    bit outf;
    inf  = in_valid && m_ready();
    outf = m_valid() && out_ready;
    @(posedge clk);
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, W'($urandom), 1'b0, 1'b0);
    adv();
    adv();
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_data, occupancy} !==
        {1'b1, 1'b0, BUB, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_hold: rdy/vld/data/occ %b/%b/%h/%0d want 1/0/%h/0",
               in_ready, out_valid, out_data, occupancy, BUB);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_data, occupancy} !==
        {1'b1, 1'b0, BUB, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_rel: rdy/vld/data/occ %b/%b/%h/%0d want 1/0/%h/0",
               in_ready, out_valid, out_data, occupancy, BUB);
    end
    adv();
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      @(negedge clk);
      vectors++;
      if ({in_ready, out_valid, out_data, occupancy} !==
          {m_ready(), m_valid(), m_data(), m_occ()}) begin
        miscompares++;
        $display("FAIL stream_model %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d",
                 i, in_ready, out_valid, out_data, occupancy,
                 m_ready(), m_valid(), m_data(), m_occ());
      end
      if (i > 1) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== W'(i - 1)) begin
          miscompares++;
          $display("FAIL stream_out %0d: vld %b data %h want 1 %h",
                   i, out_valid, out_data, W'(i - 1));
        end
      end
      adv();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== W'(10)) begin
      miscompares++;
      $display("FAIL stream_last: vld %b data %h want 1 %h",
               out_valid, out_data, W'(10));
    end
    adv();
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== BUB) begin
      miscompares++;
      $display("FAIL stream_drain: vld %b data %h want 0 %h",
               out_valid, out_data, BUB);
    end
    adv();
  endtask

  task automatic test_stall();
    logic [W-1:0] got[$];
    bit taken;
    drive(1'b1, AA, 1'b0, 1'b0);
    adv();
    drive(1'b1, BB, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (in_ready !== SKID) begin
      miscompares++;
      $display("FAIL stall_ready: in_ready %b want %b", in_ready, SKID);
    end
    taken = SKID;
    adv();
    for (int k = 0; k < 2; k++) begin
      drive(!taken, BB, 1'b0, 1'b0);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== AA ||
          occupancy !== m_occ()) begin
        miscompares++;
        $display("FAIL stall_hold %0d: vld %b data %h occ %0d want 1 %h %0d",
                 k, out_valid, out_data, occupancy, AA, m_occ());
      end
      adv();
    end
`ifdef PIPE_STAGE_SKID_EN
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_two: occ %0d rdy %b want 2 0",
               occupancy, in_ready);
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_two_comb: in_ready %b want 0", in_ready);
    end
    out_ready = 1'b0;
    adv();
`endif
    for (int k = 0; k < 4; k++) begin
      drive(!taken, BB, 1'b1, 1'b0);
      @(negedge clk);
      vectors++;
      if ({in_ready, out_valid, out_data, occupancy} !==
          {m_ready(), m_valid(), m_data(), m_occ()}) begin
        miscompares++;
        $display("FAIL stall_drain %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d",
                 k, in_ready, out_valid, out_data, occupancy,
                 m_ready(), m_valid(), m_data(), m_occ());
      end
      if (out_valid === 1'b1) got.push_back(out_data);
      if (in_valid && in_ready === 1'b1) taken = 1'b1;
      adv();
    end
    vectors++;
    if (got.size() != 2 || got[0] !== AA || got[1] !== BB) begin
      miscompares++;
      $display("FAIL stall_order: %0d beats first %h want AA,BB",
               got.size(), (got.size() > 0) ? got[0] : BUB);
    end
  endtask

  task automatic test_flush_two();
    drive(1'b1, AA, 1'b0, 1'b0);
    adv();
    drive(1'b1, BB, 1'b0, 1'b0);
    adv();
    drive(1'b1, CC, 1'b0, 1'b1);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== AA ||
        occupancy !== (SKID ? 2'd2 : 2'd1)) begin
      miscompares++;
      $display("FAIL flush_pre: vld %b data %h occ %0d",
               out_valid, out_data, occupancy);
    end
    adv();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_data, occupancy} !==
        {1'b1, 1'b0, BUB, 2'd0}) begin
      miscompares++;
      $display("FAIL flush_empty: rdy/vld/data/occ %b/%b/%h/%0d want 1/0/%h/0",
               in_ready, out_valid, out_data, occupancy, BUB);
    end
    adv();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || out_data !== BUB) begin
        miscompares++;
        $display("FAIL flush_ghost %0d: vld %b data %h want 0 %h",
                 k, out_valid, out_data, BUB);
      end
      adv();
    end
  endtask

  task automatic test_flush_fire();
    int seen;
    seen = 0;
    drive(1'b1, DD, 1'b0, 1'b0);
    adv();
    drive(1'b0, '0, 1'b1, 1'b1);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DD) begin
      miscompares++;
      $display("FAIL flfire_out: vld %b data %h want 1 %h",
               out_valid, out_data, DD);
    end
    if (out_valid === 1'b1 && out_data === DD) seen++;
    adv();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
      if (out_valid === 1'b1 && out_data === DD) seen++;
      adv();
    end
    vectors++;
    if (seen != 1 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL flfire_once: delivered %0d occ %0d want 1 0",
               seen, occupancy);
    end
  endtask

  task automatic test_random();
    bit           iv;
    bit           ordy;
    bit           fl;
    bit           acc;
    logic [W-1:0] cur;
    int           seq;
    iv  = 1'b0;
    cur = '0;
    seq = 1;
    for (int c = 0; c < 10000; c++) begin
      if (!iv) begin
        iv = ($urandom % 4) != 0;
        cur = {9'(seq), 32'($urandom)};
        seq++;
      end
      ordy = ($urandom % 3) != 0;
      fl   = ($urandom % 64) == 0;
      drive(iv, cur, ordy, fl);
      @(negedge clk);
      vectors++;
      if ({in_ready, out_valid, out_data, occupancy} !==
          {m_ready(), m_valid(), m_data(), m_occ()}) begin
        miscompares++;
        $display("FAIL random %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d",
                 c, in_ready, out_valid, out_data, occupancy,
                 m_ready(), m_valid(), m_data(), m_occ());
      end
`ifdef PIPE_STAGE_SKID_EN
      out_ready = !ordy;
      #1;
      vectors++;
      if (in_ready !== m_ready()) begin
        miscompares++;
        $display("FAIL random_rdy_dep %0d: in_ready %b want %b",
                 c, in_ready, m_ready());
      end
      out_ready = ordy;
`endif
      acc = iv && (m_ready() || fl);
      adv();
      if (acc) iv = 1'b0;
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    adv();
    adv();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_stream();
    test_stall();
    test_flush_two();
    test_flush_fire();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
